// File: rtl/ddfs_sweep_ctrl.sv
// Frequency-sweep scheduler driving the DDFS phase accumulator's ftw, enable tick and phase clear.
// Build option DDFS_SWEEP_TRIANGLE_EN: repeating sweeps bounce between the limits instead of restarting.
module ddfs_sweep_ctrl #(
    parameter int unsigned W  = 8,
    parameter int unsigned DW = 16,
    parameter int unsigned L  = 521
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [W-1:0]  cfg_start_ftw,
    input  logic [W-1:0]  cfg_stop_ftw,
    input  logic [W-1:0]  cfg_step,
    input  logic [DW-1:0] cfg_dwell,
    input  logic          cfg_repeat,
    input  logic          abort,
    output logic [W-1:0]  ftw,
    output logic          acc_enable,
    output logic          acc_clear,
    output logic          busy,
    output logic          sweep_done
);

    localparam int unsigned TW = (L > 1) ? $clog2(L) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(L - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_STEP,
        S_DONE
    } state_t;

    state_t        state, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [DW-1:0] dwell_cfg_q, dwell_cfg_d;
    logic [W-1:0]  start_q, start_d;
    logic [W-1:0]  stop_q, stop_d;
    logic [W-1:0]  step_q, step_d;
    logic          rep_q, rep_d;
    logic          up_q, up_d;
    logic [W-1:0]  ftw_d;
    logic          accept;
    logic [DW-1:0] dwell_load;
    logic [W:0]    step_sum;
    logic          over;

    assign cfg_ready  = (state == S_IDLE) && !abort;
    assign accept     = cfg_valid && cfg_ready;
    assign dwell_load = (dwell_cfg_q == '0) ? DW'(1) : dwell_cfg_q;

    // Next candidate at W+1 bits so carry/borrow shows up in the top bit.
    assign step_sum = up_q ? ({1'b0, ftw} + {1'b0, step_q}) : ({1'b0, ftw} - {1'b0, step_q});
    assign over     = (step_q == '0) || step_sum[W] ||
                      (up_q ? (step_sum[W-1:0] > stop_q) : (step_sum[W-1:0] < stop_q));

`ifdef DDFS_SWEEP_TRIANGLE_EN
    // Step taken in the reversed direction, checked against the new limit (old start).
    logic [W:0] rev_sum;
    logic       rev_over;
    assign rev_sum  = up_q ? ({1'b0, ftw} - {1'b0, step_q}) : ({1'b0, ftw} + {1'b0, step_q});
    assign rev_over = (step_q == '0) || rev_sum[W] ||
                      (up_q ? (rev_sum[W-1:0] < start_q) : (rev_sum[W-1:0] > start_q));
`endif

    always_comb begin
        state_d     = state;
        ftw_d       = ftw;
        tick_d      = '0;
        dwell_d     = dwell_q;
        dwell_cfg_d = dwell_cfg_q;
        start_d     = start_q;
        stop_d      = stop_q;
        step_d      = step_q;
        rep_d       = rep_q;
        up_d        = up_q;

        if (abort && (state != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state_d     = S_LOAD;
                        start_d     = cfg_start_ftw;
                        stop_d      = cfg_stop_ftw;
                        step_d      = cfg_step;
                        dwell_cfg_d = cfg_dwell;
                        rep_d       = cfg_repeat;
                        up_d        = (cfg_start_ftw <= cfg_stop_ftw);
                        ftw_d       = cfg_start_ftw;
                        dwell_d     = (cfg_dwell == '0) ? DW'(1) : cfg_dwell;
                    end
                end
                S_LOAD: begin
                    state_d = S_RUN;
                end
                S_RUN: begin
                    if (tick_q == TICK_LAST) begin
                        dwell_d = dwell_q - DW'(1);
                        if (dwell_q <= DW'(1)) begin
                            state_d = S_STEP;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                S_STEP: begin
                    if (!over) begin
                        ftw_d   = step_sum[W-1:0];
                        dwell_d = dwell_load;
                        state_d = S_RUN;
                    end else if (!rep_q) begin
                        state_d = S_DONE;
                    end else begin
`ifdef DDFS_SWEEP_TRIANGLE_EN
                        // Land on the limit unless already there, then head back.
                        if (ftw != stop_q) begin
                            ftw_d = stop_q;
                        end else begin
                            ftw_d = rev_over ? start_q : rev_sum[W-1:0];
                        end
                        up_d    = !up_q;
                        start_d = stop_q;
                        stop_d  = start_q;
                        dwell_d = dwell_load;
                        state_d = S_RUN;
`else
                        ftw_d   = start_q;
                        dwell_d = dwell_load;
                        state_d = S_LOAD;
`endif
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            state       <= S_IDLE;
            ftw         <= '0;
            tick_q      <= '0;
            dwell_q     <= '0;
            dwell_cfg_q <= '0;
            start_q     <= '0;
            stop_q      <= '0;
            step_q      <= '0;
            rep_q       <= 1'b0;
            up_q        <= 1'b0;
            acc_enable  <= 1'b0;
            acc_clear   <= 1'b0;
            busy        <= 1'b0;
            sweep_done  <= 1'b0;
        end else begin
            state       <= state_d;
            ftw         <= ftw_d;
            tick_q      <= tick_d;
            dwell_q     <= dwell_d;
            dwell_cfg_q <= dwell_cfg_d;
            start_q     <= start_d;
            stop_q      <= stop_d;
            step_q      <= step_d;
            rep_q       <= rep_d;
            up_q        <= up_d;
            acc_enable  <= (state_d == S_RUN) && (tick_d == TICK_LAST);
            acc_clear   <= (state_d == S_LOAD);
            busy        <= (state_d != S_IDLE);
            sweep_done  <= (state_d == S_DONE);
        end
    end

endmodule

// File: tb/tb_ddfs_sweep_ctrl.sv
// Scoreboard bench for ddfs_sweep_ctrl: expected clear/enable/done events with ftw and spacing.
module tb_ddfs_sweep_ctrl;

    localparam int unsigned W  = 8;
    localparam int unsigned DW = 16;
    localparam int unsigned L  = 4;
    localparam int FTW_MAX = (1 << W) - 1;
    localparam int EV_CLR  = 1;
    localparam int EV_EN   = 2;
    localparam int EV_DONE = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [W-1:0]  cfg_start_ftw = '0;
    logic [W-1:0]  cfg_stop_ftw = '0;
    logic [W-1:0]  cfg_step = '0;
    logic [DW-1:0] cfg_dwell = '0;
    logic          cfg_repeat = 1'b0;
    logic          abort = 1'b0;
    logic [W-1:0]  ftw;
    logic          acc_enable;
    logic          acc_clear;
    logic          busy;
    logic          sweep_done;

    always #5 clk = ~clk;

    ddfs_sweep_ctrl #(.W(W), .DW(DW), .L(L)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_start_ftw(cfg_start_ftw),
        .cfg_stop_ftw (cfg_stop_ftw),
        .cfg_step     (cfg_step),
        .cfg_dwell    (cfg_dwell),
        .cfg_repeat   (cfg_repeat),
        .abort        (abort),
        .ftw          (ftw),
        .acc_enable   (acc_enable),
        .acc_clear    (acc_clear),
        .busy         (busy),
        .sweep_done   (sweep_done)
    );

    typedef struct {
        int kind;
        int val;
        int gap;   // cycles since previous event, 0 = not checked
    } ev_t;

    ev_t exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;
    int  cyc = 0;
    int  last_ev = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_ev(input int kind, input int val, input int gap);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.gap  = gap;
        exp_q.push_back(e);
    endtask

    // Reference sweep: emits the events a sweep should produce, up to max_en enables.
    task automatic push_sweep(input int s, input int e, input int st, input int dw,
                              input int rep, input int max_en);
        int d, cur, nxt, n, gap, tmp;
        bit up, ovr;
        d   = (dw == 0) ? 1 : dw;
        up  = (s <= e);
        cur = s;
        n   = 0;
        gap = L;
        push_ev(EV_CLR, cur, 0);
        forever begin
            for (int k = 0; k < d; k++) begin
                if (n == max_en) return;
                push_ev(EV_EN, cur, (k == 0) ? gap : L);
                n++;
            end
            nxt = up ? cur + st : cur - st;
            ovr = (st == 0) || (up ? (nxt > e || nxt > FTW_MAX) : (nxt < e || nxt < 0));
            if (!ovr) begin
                cur = nxt;
                gap = L + 1;
            end else if (rep == 0) begin
                push_ev(EV_DONE, cur, 2);
                return;
            end else begin
`ifdef DDFS_SWEEP_TRIANGLE_EN
                if (cur != e) begin
                    cur = e;
                end else begin
                    nxt = up ? cur - st : cur + st;
                    cur = (st == 0 || (up ? nxt < s : nxt > s)) ? s : nxt;
                end
                tmp = s;
                s   = e;
                e   = tmp;
                up  = !up;
                gap = L + 1;
`else
                push_ev(EV_CLR, s, 2);
                cur = s;
                gap = L;
`endif
            end
        end
    endtask

    // Monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        int   kind;
        ev_t  e;
        cyc++;
        if (reset_n === 1'b0 && (acc_clear === 1'b1 || acc_enable === 1'b1 || sweep_done === 1'b1)) begin
            kind = (acc_clear === 1'b1) ? EV_CLR : (acc_enable === 1'b1) ? EV_EN : EV_DONE;
            check_eq("strobe_onehot", 32'(int'(acc_clear) + int'(acc_enable) + int'(sweep_done)), 1);
            if (exp_q.size() == 0) begin
                check_eq("unexpected_event", kind, 0);
            end else begin
                e = exp_q.pop_front();
                check_eq("ev_kind", kind, e.kind);
                check_eq("ev_ftw", 32'(ftw), e.val);
                if (e.gap != 0) check_eq("ev_gap", cyc - last_ev, e.gap);
            end
            last_ev = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start_cfg(input int s, input int e, input int st, input int dw, input int rep);
        check_eq("cfg_ready_before_accept", cfg_ready, 1);
        cfg_start_ftw = W'(s);
        cfg_stop_ftw  = W'(e);
        cfg_step      = W'(st);
        cfg_dwell     = DW'(dw);
        cfg_repeat    = rep[0];
        cfg_valid     = 1'b1;
        tick();
        cfg_valid     = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < budget) begin
            tick();
            i++;
        end
        check_eq({tag, "_drained"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic check_idle(input string tag, input int exp_ftw);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_ftw"}, ftw, exp_ftw);
        check_eq({tag, "_cfg_ready"}, cfg_ready, 1);
        check_eq({tag, "_acc_enable"}, acc_enable, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_abort;

        // Reset state
        tick();
        tick();
        check_eq("rst_ftw", ftw, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_acc_enable", acc_enable, 0);
        check_eq("rst_acc_clear", acc_clear, 0);
        check_eq("rst_sweep_done", sweep_done, 0);
        check_eq("rst_cfg_ready", cfg_ready, 1);
        reset_n = 1'b0;
        tick();

        // Up sweep 10..13, dwell 2
        push_sweep(10, 13, 1, 2, 0, 1000);
        start_cfg(10, 13, 1, 2, 0);
        drain("t1", 200);
        check_idle("t1_end", 13);
        tick();
        tick();
        check_eq("t1_hold_ftw", ftw, 13);

        // Synchronous reset mid-run at ftw=11
        push_sweep(10, 13, 1, 2, 0, 3);
        start_cfg(10, 13, 1, 2, 0);
        drain("t5", 200);
        check_eq("t5_pre_ftw", ftw, 11);
        check_eq("t5_pre_busy", busy, 1);
        reset_n = 1'b1;
        tick();
        check_eq("t5_rst_acc_clear", acc_clear, 0);
        check_eq("t5_rst_sweep_done", sweep_done, 0);
        check_idle("t5_rst", 0);
        reset_n = 1'b0;
        tick();

        // Down sweep 200..190 step 4, accepted right after reset
        push_sweep(200, 190, 4, 1, 0, 1000);
        start_cfg(200, 190, 4, 1, 0);
        drain("t2", 200);
        check_idle("t2_end", 192);

        // Dwell of 0 behaves as 1
        push_sweep(5, 3, 1, 0, 0, 1000);
        start_cfg(5, 3, 1, 0, 0);
        drain("t2b", 200);
        check_idle("t2b_end", 3);

        // Carry out of W bits ends the sweep
        push_sweep(250, 255, 4, 1, 0, 1000);
        start_cfg(250, 255, 4, 1, 0);
        drain("t3", 200);
        check_idle("t3_end", 254);

        // Zero step: single value then done
        push_sweep(50, 60, 0, 3, 0, 1000);
        start_cfg(50, 60, 0, 3, 0);
        drain("t3b", 200);
        check_idle("t3b_end", 50);

        // Repeating sweep, then abort while ftw=1
`ifdef DDFS_SWEEP_TRIANGLE_EN
        n_abort = 6;
`else
        n_abort = 5;
`endif
        push_sweep(0, 2, 1, 1, 1, n_abort);
        start_cfg(0, 2, 1, 1, 1);
        drain("t4", 200);
        check_eq("t4_pre_abort_ftw", ftw, 1);
        abort = 1'b1;
        tick();
        check_eq("t4_abort_busy", busy, 0);
        check_eq("t4_abort_ftw", ftw, 1);
        check_eq("t4_abort_acc_enable", acc_enable, 0);
        check_eq("t4_abort_sweep_done", sweep_done, 0);
        check_eq("t4_abort_cfg_ready", cfg_ready, 0);
        cfg_start_ftw = W'(7);
        cfg_stop_ftw  = W'(9);
        cfg_step      = W'(1);
        cfg_dwell     = DW'(1);
        cfg_valid     = 1'b1;
        tick();
        check_eq("t4_blocked_busy", busy, 0);
        tick();
        check_eq("t4_blocked_busy2", busy, 0);
        check_eq("t4_blocked_ftw", ftw, 1);
        cfg_valid = 1'b0;
        abort     = 1'b0;
        tick();
        check_idle("t4_end", 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ddfs_sweep_ctrl.md
Name: ddfs_sweep_ctrl

Overview:
Frequency-sweep scheduler for the IQ DDFS datapath. It accepts a sweep configuration over a valid/ready handshake, then drives the phase accumulator's frequency tuning word (ftw), enable strobe and clear pulse. It steps ftw from a start value toward a stop value, holding each value for a programmed number of accumulator ticks. It replaces the fixed ftw and the free-running time base currently feeding the accumulator.

Parameters:
W, 8, ftw width (matches the phase accumulator).
DW, 16, dwell counter width.
L, 521, clock cycles per accumulator enable tick.

Ports:
clk  in  1  system clock
reset_n  in  1  reset; one clock; reset is synchronous and active-high (reset_n=1 resets)
cfg_valid  in  1  config offered
cfg_ready  out  1  config can be accepted
cfg_start_ftw  in  W  first ftw of sweep
cfg_stop_ftw  in  W  sweep limit
cfg_step  in  W  ftw increment magnitude
cfg_dwell  in  DW  enable ticks per ftw value
cfg_repeat  in  1  restart sweep at end instead of finishing
abort  in  1  terminate sweep
ftw  out  W  tuning word to accumulator
acc_enable  out  1  accumulator enable strobe
acc_clear  out  1  one-cycle accumulator phase clear
busy  out  1  state != IDLE
sweep_done  out  1  one-cycle end-of-sweep pulse

Behaviour:
- Reset: state=IDLE; ftw=0; acc_enable=0; acc_clear=0; busy=0; sweep_done=0; tick and dwell counters=0; cfg_ready=1.
- cfg_ready = (state==IDLE) && !abort, combinational. Accept occurs when cfg_valid && cfg_ready; all cfg_* fields are registered on accept. Direction is latched as up if start<=stop, otherwise down.
- States: IDLE, LOAD, RUN, STEP, DONE.
- IDLE->LOAD on accept. In LOAD (1 cycle): ftw=start, acc_clear=1, dwell counter=max(cfg_dwell,1). Then ->RUN.
- RUN: the tick counter counts 0..L-1. acc_enable=1 for one cycle when the counter is at L-1. The counter is held at 0 outside RUN and resets to 0 on entry to RUN. Each acc_enable decrements dwell; the enable that brings dwell to 0 moves the FSM to STEP on the next cycle.
- Latency: first acc_enable occurs L cycles after entering RUN. Each ftw value is held for dwell*L cycles plus 1 STEP cycle.
- STEP (1 cycle, acc_enable=0): next is computed at W+1 bits; up: ftw+step, down: ftw-step.
  - Overshoot = carry, borrow, next>stop (up) or next<stop (down). step=0 counts as overshoot.
  - No overshoot: ftw=next, reload dwell, ->RUN.
  - Overshoot with repeat=0: ->DONE, ftw holds the last value.
  - Overshoot with repeat=1: ->LOAD (sawtooth restart, with acc_clear).
- DONE (1 cycle): sweep_done=1, then ->IDLE. ftw holds in IDLE; acc_enable stays 0.
- abort in any non-IDLE state: next state is IDLE, ftw holds, no sweep_done, no acc_clear. abort in IDLE has no effect. abort concurrent with cfg_valid: no accept.
- Reset in any state overrides everything; all outputs take reset values on the next edge.

Optional Feature:
DDFS_SWEEP_TRIANGLE_EN: applies only to the overshoot-with-repeat=1 case.
- Defined: on overshoot, ftw=current limit (stop, or start on the return leg), direction toggles, limits swap, dwell reloads, ->RUN, no acc_clear. This produces a continuous triangle sweep with no repeated value at the turn beyond its own dwell.
- Undefined: sawtooth restart via LOAD as above.

Test Plan:
1. L=4, start=10, stop=13, step=1, dwell=2, repeat=0 -> ftw 10,11,12,13, each held 9 cycles (8 + STEP); one sweep_done pulse; ftw stays 13; busy=0; cfg_ready=1.
2. start=200, stop=190, step=4, dwell=1 -> ftw 200,196,192, then sweep_done (188<190).
3. start=250, stop=255, step=4 -> ftw 250,254, then done (258 carries out of 8 bits); step=0 run -> single ftw=start dwell, then done.
4. start=0, stop=2, step=1, repeat=1 -> ftw 0,1,2,0,1... with acc_clear pulse on every LOAD. Assert abort while ftw=1 -> busy=0 next cycle, ftw=1, acc_enable=0, no sweep_done. cfg_valid with abort high -> not accepted.
5. reset_n=1 mid-RUN at ftw=11 -> next cycle ftw=0, all outputs 0, cfg_ready=1, new config accepted normally.
6. With DDFS_SWEEP_TRIANGLE_EN, start=0, stop=2, step=1, repeat=1 -> ftw 0,1,2,1,0,1,2...; acc_clear only at the initial LOAD.
